// File: rtl/looped_gate_array.sv
// WIDTH-lane gate loop: each lane feeds op(input1, output1) through a DEPTH-stage
// register chain, with a parallel load and a saturating stage[0] change counter.
module looped_gate_array #(
    parameter int unsigned       WIDTH   = 8,
    parameter int unsigned       DEPTH   = 1,
    parameter int unsigned       CNT_W   = 8,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] gate_out,
    output logic [WIDTH-1:0] output1,
    output logic [CNT_W-1:0] change_count
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign output1      = stage_q[DEPTH-1];
    assign change_count = cnt_q;

    always_comb begin
        gate_out = '0;
        unique case (mode)
            2'd0: gate_out = ~(input1 & output1);
            2'd1: gate_out = ~(input1 | output1);
            2'd2: gate_out = input1 ^ output1;
            2'd3: gate_out = ~(input1 ^ output1);
            default: gate_out = '0;
        endcase
    end

    // Count only advancing edges that actually change stage[0]; stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if ((gate_out != stage_q[0]) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= RST_VAL;
            end
            cnt_q <= '0;
        end else if (load) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= load_data;
            end
            cnt_q <= '0;
        end else if (en) begin
            stage_q[0] <= gate_out;
            for (int k = 1; k < DEPTH; k++) begin
                stage_q[k] <= stage_q[k-1];
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_looped_gate_array.sv
// Directed bench for looped_gate_array across several parameterisations, using an
// expected-value queue popped and compared after each DUT update.
module tb_looped_gate_array;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // A: WIDTH=1 DEPTH=1 (original NAND loop)
    logic       a_rst, a_en, a_load;
    logic [1:0] a_mode;
    logic [0:0] a_ld, a_in, a_g, a_o;
    logic [7:0] a_cnt;
    // B: WIDTH=4 DEPTH=3
    logic       b_rst, b_en, b_load;
    logic [1:0] b_mode;
    logic [3:0] b_ld, b_in, b_g, b_o;
    logic [7:0] b_cnt;
    // C: WIDTH=8 DEPTH=1, non-zero reset value
    logic       c_rst, c_en, c_load;
    logic [1:0] c_mode;
    logic [7:0] c_ld, c_in, c_g, c_o;
    logic [7:0] c_cnt;
    // E: WIDTH=1 CNT_W=2 (saturation)
    logic       e_rst, e_en, e_load;
    logic [1:0] e_mode;
    logic [0:0] e_ld, e_in, e_g, e_o;
    logic [1:0] e_cnt;

    looped_gate_array #(.WIDTH(1), .DEPTH(1), .CNT_W(8), .RST_VAL(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .mode(a_mode), .load(a_load),
        .load_data(a_ld), .input1(a_in), .gate_out(a_g), .output1(a_o),
        .change_count(a_cnt)
    );
    looped_gate_array #(.WIDTH(4), .DEPTH(3), .CNT_W(8), .RST_VAL(4'h0)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .mode(b_mode), .load(b_load),
        .load_data(b_ld), .input1(b_in), .gate_out(b_g), .output1(b_o),
        .change_count(b_cnt)
    );
    looped_gate_array #(.WIDTH(8), .DEPTH(1), .CNT_W(8), .RST_VAL(8'h3C)) u_c (
        .clk(clk), .rst(c_rst), .en(c_en), .mode(c_mode), .load(c_load),
        .load_data(c_ld), .input1(c_in), .gate_out(c_g), .output1(c_o),
        .change_count(c_cnt)
    );
    looped_gate_array #(.WIDTH(1), .DEPTH(1), .CNT_W(2), .RST_VAL(1'b0)) u_e (
        .clk(clk), .rst(e_rst), .en(e_en), .mode(e_mode), .load(e_load),
        .load_data(e_ld), .input1(e_in), .gate_out(e_g), .output1(e_o),
        .change_count(e_cnt)
    );

    // Reference model for instance C.
    logic [7:0] m_state;
    logic [7:0] m_cnt;

    function automatic logic [7:0] op8(input logic [1:0] md, input logic [7:0] x,
                                       input logic [7:0] y);
        case (md)
            2'd0:    return ~(x & y);
            2'd1:    return ~(x | y);
            2'd2:    return x ^ y;
            default: return ~(x ^ y);
        endcase
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed %h expected <entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance C one step with the model and check output and count.
    task automatic c_step(input string tag, input logic [7:0] in_v);
        logic [7:0] g;
        c_in = in_v;
        c_en = 1'b1;
        g = op8(c_mode, in_v, m_state);
        if (g != m_state && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
        m_state = g;
        push({tag, "_out"}, 32'(m_state));
        push({tag, "_cnt"}, 32'(m_cnt));
        tick();
        check(32'(c_o));
        check(32'(c_cnt));
    endtask

    logic [0:0] t1_in  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [0:0] t1_out [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] t2_out [6] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h0};
    logic [1:0] t5_cnt [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        {a_rst, a_en, a_load, a_mode, a_ld, a_in} = '0;
        {b_rst, b_en, b_load, b_mode, b_ld, b_in} = '0;
        {c_rst, c_en, c_load, c_mode, c_ld, c_in} = '0;
        {e_rst, e_en, e_load, e_mode, e_ld, e_in} = '0;
        tick();
        tick();
        push("rst_a_out", 32'h0);  check(32'(a_o));
        push("rst_c_out", 32'h3C); check(32'(c_o));
        push("rst_c_cnt", 32'h0);  check(32'(c_cnt));
        push("rst_e_cnt", 32'h0);  check(32'(e_cnt));
        {a_rst, b_rst, c_rst, e_rst} = 4'hF;
        m_state = 8'h3C;
        m_cnt   = 8'h00;

        // 1: NAND loop, single lane
        a_mode = 2'd0;
        a_en   = 1'b1;
        for (int i = 0; i < 7; i++) begin
            a_in = t1_in[i];
            push($sformatf("t1_out%0d", i), 32'(t1_out[i]));
            tick();
            check(32'(a_o));
        end
        push("t1_cnt", 32'd5);
        check(32'(a_cnt));

        // 2: XOR square wave through 3 stages
        b_mode = 2'd2;
        b_load = 1'b1;
        b_ld   = 4'h0;
        tick();
        b_load = 1'b0;
        b_in   = 4'hF;
        b_en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("t2_out%0d", i), 32'(t2_out[i]));
            tick();
            check(32'(b_o));
        end

        // 3: hold with en=0 while inputs and mode wiggle
        c_mode = 2'd2;
        for (int i = 0; i < 4; i++) c_step($sformatf("t3_run%0d", i), 8'($urandom));
        c_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c_in   = ~c_in;
            c_mode = 2'(i);
            push($sformatf("t3_hold%0d_out", i), 32'(m_state));
            push($sformatf("t3_hold%0d_cnt", i), 32'(m_cnt));
            tick();
            check(32'(c_o));
            check(32'(c_cnt));
        end
        c_mode = 2'd3;
        for (int i = 0; i < 3; i++) c_step($sformatf("t3_resume%0d", i), 8'($urandom));

        // 4: load wins over en
        c_load = 1'b1;
        c_en   = 1'b1;
        c_ld   = 8'hA5;
        c_in   = 8'hFF;
        push("t4_out", 32'hA5);
        push("t4_cnt", 32'h0);
        tick();
        check(32'(c_o));
        check(32'(c_cnt));
        m_state = 8'hA5;
        m_cnt   = 8'h00;
        c_load  = 1'b0;
        c_en    = 1'b0;
        c_in    = 8'h0F;
        c_mode = 2'd0; #1; push("g_nand", 32'hFA); check(32'(c_g));
        c_mode = 2'd1; #1; push("g_nor",  32'h50); check(32'(c_g));
        c_mode = 2'd2; #1; push("g_xor",  32'hAA); check(32'(c_g));
        c_mode = 2'd3; #1; push("g_xnor", 32'h55); check(32'(c_g));

        // 5: 2-bit counter saturates
        e_mode = 2'd1;
        e_in   = 1'b0;
        e_en   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("t5_cnt%0d", i), 32'(t5_cnt[i]));
            tick();
            check(32'(e_cnt));
        end

        // 6: async reset mid-cycle, held across an edge, then resume
        c_mode = 2'd2;
        c_step("t6_pre0", 8'h81);
        c_step("t6_pre1", 8'h7E);
        #2;
        c_rst = 1'b0;
        #1;
        push("t6_rst_out", 32'h3C); check(32'(c_o));
        push("t6_rst_cnt", 32'h0);  check(32'(c_cnt));
        c_en = 1'b1;
        tick();
        push("t6_rsthold_out", 32'h3C); check(32'(c_o));
        c_rst   = 1'b1;
        m_state = 8'h3C;
        m_cnt   = 8'h00;
        c_step("t6_post0", 8'h0F);
        c_step("t6_post1", 8'hF0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
